pixel_to_wide_packer: RTL and testbench
=======================================

// Module: pixel_to_wide_packer
// PURPOSE
//  Packs a narrow pixel stream (PSIZE bits/pixel) into a contiguous MSB-first bitstream of DSIZE-bit bus words.
//  Sits on the VDMA write path, between the video pixel source and the AXI write-data FIFO.
//  Its output is the wide packed format that the wide-data probe/unpacker stages consume.
//  No gaps between pixels; a pixel may straddle two bus words (256/24: 32 pixels -> 3 words).
// PARAMETERS
//  DSIZE  256  output bus width, bits
//  PSIZE  24   pixel width, bits; PSIZE < DSIZE is required (elaboration $error otherwise)
// PORTS
//  clock      in   1      clock
//  rst        in   1      asynchronous, active-high reset
//  in_data    in   PSIZE  pixel
//  in_valid   in   1      pixel valid
//  in_last    in   1      last pixel of frame (qualified by in_valid)
//  in_ready   out  1      pixel accepted when in_valid && in_ready
//  out_data   out  DSIZE  packed word
//  out_valid  out  1      word valid
//  out_last   out  1      final word of frame
//  out_ready  in   1      word consumed when out_valid && out_ready
// BEHAVIOUR
//  - Reset values: out_data=0, out_valid=0, out_last=0, in_ready=1, accumulator=0, bit count=0, state FILL.
//  - Accumulator: acc[DSIZE+PSIZE-1:0] plus bcnt of width $clog2(DSIZE+PSIZE)+1.
//    An accepted pixel is appended directly below the bcnt valid MSB-aligned bits; bcnt += PSIZE.
//  - Bit ordering: pixel 0 of a word occupies out_data[DSIZE-1 -: PSIZE].
//    A straddling pixel puts its MS bits at the tail of word n and its LS bits at the head of word n+1.
//  - Word completion (bcnt+PSIZE >= DSIZE on accept):
//    top DSIZE bits go to the output register; the residue shifts to the MSB; bcnt -= DSIZE.
//    out_valid rises the cycle after the completing accept (latency 1).
//  - Output register: out_data/out_last are held stable while out_valid && !out_ready.
//  - in_ready = !(out_valid && !out_ready) && state==FILL. It is combinational from out_ready.
//    Accept and output drain in the same cycle is allowed, giving full throughput (1 pixel/clk).
//  - FSM, 2 states:
//    FILL  : normal packing.
//    FLUSH : a residue word is pending after a last pixel that both completed a word and left a residue.
//            It is entered on that event. The residue word (zero-padded LSBs, out_last=1) is loaded
//            when the output register frees up, then the FSM returns to FILL. in_ready=0 while in FLUSH.
//  - Frame end (macro enabled), based on the accept of the in_last pixel:
//    * bcnt_after==0: the completing word carries out_last=1.
//    * 0<bcnt_after<DSIZE with no completion: the partial word is zero-padded and emitted with out_last=1.
//    * Completion plus residue: the full word is emitted with out_last=0, then FLUSH emits the residue.
//    After out_last, the accumulator and bcnt are 0, so the next frame starts word-aligned.
//  - Reset mid-operation: all state is cleared immediately; any partial word is discarded; no output pulse.
// CONFIGURATION
//  PACKER_FRAME_FLUSH_EN defined: in_last handling and the FLUSH state are as above.
//  PACKER_FRAME_FLUSH_EN undefined: in_last is ignored, out_last is tied to 0, and FLUSH is unreachable.
//    The residue carries over across frames, i.e. one continuous bitstream.
// STRUCTURE
//  Shared package vdma_pack_pkg holds:
//    typedef enum logic {FILL, FLUSH} pack_state_e;
//    function pack_words(DSIZE,PSIZE) giving lcm/DSIZE words per pixel group;
//    localparam BCNT_W.
//  Natural sub-module: wide_out_reg, a 1-deep valid/ready output register (data+last) with a free signal.
// TESTING
//  1. pix_i=24'hC0C000+i, i=0..31, last on i=31, out_ready=1 -> exactly 3 words.
//     out_data[255:232]=C0C000; word0[15:0]=16'hC0C0; word1[255:248]=8'h0A; word2[23:0]=C0C01F with out_last=1.
//  2. 11 pixels with last on #10 -> word0 (out_last=0), then the FLUSH word {8'h0A,248'h0} with out_last=1.
//     in_ready=0 for 1 cycle between them.
//  3. 12 pixels, last on #11 -> 2nd word = {C0C00A[7:0],C0C00B,224'h0} with out_last=1; no FLUSH state entered.
//  4. Continuous input with out_ready held low 5 cycles after the first word -> in_ready=0 those cycles.
//     No pixel lost or duplicated; the stream resumes at 1 pixel/clk.
//  5. rst asserted after pixel 5 of a frame -> outputs return to reset values asynchronously.
//     A new 32-pixel frame reproduces the scenario-1 words.
//  6. Macro undefined: 2 frames of 11 pixels with last -> no out_last.
//     The 2nd frame's pixel 0 continues at bit offset 8 of word1.

Source files
------------

// File: rtl/vdma_pack_pkg.sv
// Shared types and sizing helpers for the VDMA pixel packer.
package vdma_pack_pkg;

  typedef enum logic {FILL, FLUSH} pack_state_e;

  localparam int DSIZE_DEF = 256;
  localparam int PSIZE_DEF = 24;
  localparam int BCNT_W    = $clog2(DSIZE_DEF + PSIZE_DEF) + 1;

  function automatic int bcnt_width(input int dsize, input int psize);
    return $clog2(dsize + psize) + 1;
  endfunction

  // Bus words per repeating pixel group: lcm(DSIZE,PSIZE)/DSIZE = PSIZE/gcd.
  function automatic int pack_words(input int dsize, input int psize);
    int a;
    int b;
    int t;
    a = dsize;
    b = psize;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return psize / a;
  endfunction

endpackage

// File: rtl/pixel_to_wide_packer_out_reg.sv
// wide_out_reg: 1-deep valid/ready output register carrying data and last.
module wide_out_reg #(
  parameter int DSIZE = 256
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             load,
  input  logic [DSIZE-1:0] load_data,
  input  logic             load_last,
  input  logic             out_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  output logic             free
);

  // The register can take a new word when empty or being drained this cycle.
  assign free = !out_valid || out_ready;

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_data  <= load_data;
      out_valid <= 1'b1;
      out_last  <= load_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pixel_to_wide_packer.sv
// Packs PSIZE-bit pixels MSB-first into DSIZE-bit words.
// Frame-end flushing is enabled by defining PACKER_FRAME_FLUSH_EN.
module pixel_to_wide_packer
  import vdma_pack_pkg::*;
#(
  parameter int DSIZE = 256,
  parameter int PSIZE = 24
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [PSIZE-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [DSIZE-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output pack_state_e      pack_state
);

  localparam int AW = DSIZE + PSIZE;
  localparam int CW = bcnt_width(DSIZE, PSIZE);

  if (PSIZE >= DSIZE) begin : g_size_check
    $error("pixel_to_wide_packer: PSIZE must be smaller than DSIZE");
  end

  // Handshake: a transfer happens on a clock edge where valid && ready;
  // valid never waits on ready, and in_ready depends combinationally on out_ready.

  logic [AW-1:0]    acc, acc_app, acc_nxt;
  logic [CW-1:0]    bcnt, bcnt_sum, bcnt_nxt;
  pack_state_e      state, state_nxt;
  logic             load, load_last, free, accept, last_in;
  logic [DSIZE-1:0] load_data;

`ifdef PACKER_FRAME_FLUSH_EN
  assign last_in = in_last;
`else
  logic unused_in_last;
  assign unused_in_last = in_last;
  assign last_in        = 1'b0;
`endif

  assign in_ready   = free && (state == FILL);
  assign accept     = in_valid && in_ready;
  assign pack_state = state;

  // New pixel lands directly below the bcnt valid bits held at the MSB end.
  assign acc_app  = acc | (AW'(in_data) << (CW'(DSIZE) - bcnt));
  assign bcnt_sum = bcnt + CW'(PSIZE);

  always_comb begin
    acc_nxt   = acc;
    bcnt_nxt  = bcnt;
    state_nxt = state;
    load      = 1'b0;
    load_last = 1'b0;
    load_data = acc_app[AW-1 -: DSIZE];
    case (state)
      FILL: begin
        if (accept) begin
          if (bcnt_sum >= CW'(DSIZE)) begin
            load     = 1'b1;
            acc_nxt  = acc_app << DSIZE;
            bcnt_nxt = bcnt_sum - CW'(DSIZE);
            if (last_in) begin
              if (bcnt_sum == CW'(DSIZE)) load_last = 1'b1;
              else                        state_nxt = FLUSH;
            end
          end else begin
            acc_nxt  = acc_app;
            bcnt_nxt = bcnt_sum;
            if (last_in) begin
              load      = 1'b1;
              load_last = 1'b1;
              acc_nxt   = '0;
              bcnt_nxt  = '0;
            end
          end
        end
      end
      FLUSH: begin
        load_data = acc[AW-1 -: DSIZE];
        if (free) begin
          load      = 1'b1;
          load_last = 1'b1;
          acc_nxt   = '0;
          bcnt_nxt  = '0;
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      bcnt  <= '0;
      state <= FILL;
    end else begin
      acc   <= acc_nxt;
      bcnt  <= bcnt_nxt;
      state <= state_nxt;
    end
  end

  wide_out_reg #(.DSIZE(DSIZE)) u_out_reg (
    .clock     (clock),
    .rst       (rst),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .free      (free)
  );

endmodule

// File: tb/tb_pixel_to_wide_packer.sv
// Randomized bench for pixel_to_wide_packer against a bit-queue reference model.
module tb_pixel_to_wide_packer;
  import vdma_pack_pkg::*;

  localparam int DSIZE = 256;
  localparam int PSIZE = 24;
`ifdef PACKER_FRAME_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  typedef struct packed {
    logic [PSIZE-1:0] d;
    logic             l;
  } pix_t;

  logic             clock = 1'b0;
  logic             rst;
  logic [PSIZE-1:0] in_data;
  logic             in_valid;
  logic             in_last;
  logic             in_ready;
  logic [DSIZE-1:0] out_data;
  logic             out_valid;
  logic             out_last;
  logic             out_ready;
  pack_state_e      pack_state;

  pixel_to_wide_packer #(.DSIZE(DSIZE), .PSIZE(PSIZE)) dut (
    .clock     (clock),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_last  (out_last),
    .out_ready (out_ready),
    .pack_state(pack_state)
  );

  always #5 clock = ~clock;

  int               n_vec = 0;
  int               n_err = 0;
  pix_t             pix_q[$];
  logic [DSIZE-1:0] exp_q[$];
  logic             exp_last_q[$];
  logic [DSIZE-1:0] seen_q[$];
  bit               bitq[$];
  logic [DSIZE-1:0] prev_data;
  logic             held = 1'b0;
  int               ir_low = 0;
  int               acc_cnt = 0;

  task automatic check(input string tag, input logic [DSIZE-1:0] got, input logic [DSIZE-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: the stream is a plain queue of bits; every DSIZE bits form a word.
  task automatic model_accept(input logic [PSIZE-1:0] d, input logic l);
    logic [DSIZE-1:0] w;
    for (int b = PSIZE - 1; b >= 0; b--) bitq.push_back(d[b]);
    while (bitq.size() >= DSIZE) begin
      for (int b = DSIZE - 1; b >= 0; b--) w[b] = bitq.pop_front();
      exp_q.push_back(w);
      exp_last_q.push_back(FLUSH_EN && l && bitq.size() == 0);
    end
    if (FLUSH_EN && l && bitq.size() > 0) begin
      w = '0;
      for (int b = DSIZE - 1; bitq.size() > 0; b--) w[b] = bitq.pop_front();
      exp_q.push_back(w);
      exp_last_q.push_back(1'b1);
    end
  endtask

  task automatic push_frame(input int n, input bit rnd);
    pix_t p;
    for (int i = 0; i < n; i++) begin
      p.d = rnd ? PSIZE'($urandom) : PSIZE'(24'hC0C000 + i);
      p.l = (i == n - 1);
      pix_q.push_back(p);
    end
  endtask

  task automatic step(input int vprob, input int rprob);
    @(negedge clock);
    in_valid = (pix_q.size() > 0) && ($urandom_range(99) < vprob);
    if (in_valid) begin
      in_data = pix_q[0].d;
      in_last = pix_q[0].l;
    end else begin
      in_data = PSIZE'($urandom);
      in_last = 1'($urandom);
    end
    out_ready = ($urandom_range(99) < rprob);
    #1;
    if (!in_ready) ir_low++;
    if (out_valid && !out_ready) check("stall_in_ready", in_ready, 0);
    if (held && out_valid) check("hold_data", out_data, prev_data);
    held      = out_valid && !out_ready;
    prev_data = out_data;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", out_data, 'x);
      end else begin
        check("word_data", out_data, exp_q.pop_front());
        check("word_last", out_last, exp_last_q.pop_front());
      end
      seen_q.push_back(out_data);
    end
    if (in_valid && in_ready) begin
      model_accept(pix_q[0].d, pix_q[0].l);
      void'(pix_q.pop_front());
      acc_cnt++;
    end
  endtask

  task automatic drain(input int vprob, input int rprob);
    int cyc = 0;
    while ((pix_q.size() > 0 || exp_q.size() > 0 || out_valid) && cyc < 2000) begin
      step(vprob, rprob);
      cyc++;
    end
    if (cyc >= 2000) check("drain_timeout", cyc, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_last"}, out_last, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_in_ready"}, in_ready, 1);
  endtask

  task automatic check_frame1(input string tag);
    logic [DSIZE-1:0] w;
    check({tag, "_count"}, seen_q.size(), 3);
    if (seen_q.size() == 3) begin
      w = seen_q[0];
      check({tag, "_w0_head"}, w[255:232], 24'hC0C000);
      check({tag, "_w0_tail"}, w[15:0], 16'hC0C0);
      w = seen_q[1];
      check({tag, "_w1_head"}, w[255:248], 8'h0A);
      w = seen_q[2];
      check({tag, "_w2_tail"}, w[23:0], 24'hC0C01F);
    end
  endtask

  initial begin
    int cyc;
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clock);
    check_reset_vals("reset");
    rst = 1'b0;

    // Aligned 32-pixel frame: three words.
    seen_q.delete();
    push_frame(32, 1'b0);
    drain(100, 100);
    check_frame1("frame32");

    // 11 pixels: completion plus residue, one FLUSH cycle with in_ready low.
    ir_low = 0;
    push_frame(11, 1'b0);
    drain(100, 100);
    repeat (2) step(100, 100);
    check("flush_in_ready_low", ir_low, FLUSH_EN ? 1 : 0);

    // 12 pixels: partial word padded, no flush.
    ir_low = 0;
    push_frame(12, 1'b0);
    drain(100, 100);
    repeat (2) step(100, 100);
    check("no_flush_in_ready", ir_low, 0);

    // Continuous input with a 5-cycle downstream stall after the first word.
    push_frame(40, 1'b1);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      step(100, 100);
      cyc++;
    end
    check("first_word_seen", out_valid, 1);
    repeat (5) step(100, 0);
    drain(100, 100);

    // Randomized frames with random backpressure.
    for (int f = 0; f < 8; f++) push_frame($urandom_range(1, 40), 1'b1);
    drain(70, 60);

    // Asynchronous reset after pixel 5 of a frame.
    push_frame(32, 1'b1);
    acc_cnt = 0;
    cyc = 0;
    while (acc_cnt < 5 && cyc < 100) begin
      step(100, 100);
      cyc++;
    end
    check("pre_reset_accepts", acc_cnt, 5);
    @(negedge clock);
    #3 rst = 1'b1;
    #1;
    check_reset_vals("async_reset");
    pix_q.delete();
    exp_q.delete();
    exp_last_q.delete();
    bitq.delete();
    held = 1'b0;
    in_valid = 1'b0;
    repeat (2) @(negedge clock);
    rst = 1'b0;

    seen_q.delete();
    push_frame(32, 1'b0);
    drain(100, 100);
    check_frame1("post_reset");

    // Two 11-pixel frames back to back under random traffic.
    push_frame(11, 1'b0);
    push_frame(11, 1'b0);
    drain(80, 70);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
